// File: rtl/vga_scanout.sv
// vga_scanout
// Scans the capture frame buffer out as a VGA raster. The source image is
// replicated SCALE times in x and y and centred in the active area; the
// surrounding border and all blanking intervals show black. A frame-sync
// pulse from the capture side realigns the vertical position at the next
// line boundary, so the read and write frames stay phase-locked.
//
// Ports
//   i_clk          pixel clock
//   i_reset        synchronous, active-high reset
//   i_sync         one-cycle frame-sync pulse from the capture stage
//   i_bram_dout    frame buffer read data, valid one cycle after o_bram_addr
//   o_bram_addr    frame buffer read address (row-major, 0 = top-left)
//   o_bram_re      frame buffer read enable, high inside the image window
//   o_hsync        horizontal sync, active low
//   o_vsync        vertical sync, active low
//   o_video_out    pixel intensity, 0 outside the window and in blanking
//   o_de           high during the active area
//   o_frame_start  one-cycle pulse with the first active pixel of a frame
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SRC_W       = 160,
  parameter int SRC_H       = 100,
  parameter int SCALE       = 3,
  parameter int RESYNC_LINE = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sync,
  input  logic [7:0]  i_bram_dout,
  output logic [13:0] o_bram_addr,
  output logic        o_bram_re,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [7:0]  o_video_out,
  output logic        o_de,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int RW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int WIN_W   = SRC_W * SCALE;
  localparam int WIN_H   = SRC_H * SCALE;
  localparam int X0      = (H_ACTIVE - WIN_W) / 2;
  localparam int Y0      = (V_ACTIVE - WIN_H) / 2;

  localparam logic [HW-1:0] HC_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HC_ACTIVE = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] WX_BEGIN  = HW'(X0);
  localparam logic [HW-1:0] WX_END    = HW'(X0 + WIN_W);
  localparam logic [HW-1:0] WX_LAST   = HW'(X0 + WIN_W - 1);
  localparam logic [VW-1:0] VC_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VC_ACTIVE = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WY_BEGIN  = VW'(Y0);
  localparam logic [VW-1:0] WY_END    = VW'(Y0 + WIN_H);
  localparam logic [VW-1:0] VC_RESYNC = VW'(RESYNC_LINE);
  localparam logic [RW-1:0] REP_LAST  = RW'(SCALE - 1);
  localparam logic [13:0]   ROW_STEP  = 14'(SRC_W);
  localparam logic [13:0]   LAST_ROW  = 14'(SRC_W * (SRC_H - 1));

  logic [HW-1:0] r_hc;
  logic [VW-1:0] r_vc;
  logic          r_pending;
  logic [13:0]   r_addr;
  logic [13:0]   r_rowBase;
  logic [RW-1:0] r_xrep;
  logic [RW-1:0] r_yrep;

  logic [7:0]    r_data;
  logic          r_inwin1, r_inwin2;
  logic          r_hs1, r_hs2;
  logic          r_vs1, r_vs2;
  logic          r_de1, r_de2;
  logic          r_fs1, r_fs2;

  logic          w_hcWrap;
  logic          w_resync;
  logic          w_frameWrap;
  logic          w_inwin;
  logic          w_lineEnd;
  logic          w_hsyncN;
  logic          w_vsyncN;
  logic          w_active;
  logic          w_frameStart;

  // Stage-0 decode of the raster position. w_resync covers a sync pulse that
  // lands on the wrap cycle itself as well as one already pending.
  assign w_hcWrap     = (r_hc == HC_LAST);
  assign w_resync     = w_hcWrap && (r_pending || i_sync);
  assign w_frameWrap  = w_hcWrap && (r_vc == VC_LAST);
  assign w_inwin      = (r_hc >= WX_BEGIN) && (r_hc < WX_END) &&
                        (r_vc >= WY_BEGIN) && (r_vc < WY_END);
  assign w_lineEnd    = w_inwin && (r_hc == WX_LAST);
  assign w_hsyncN     = !((r_hc >= HS_BEGIN) && (r_hc < HS_END));
  assign w_vsyncN     = !((r_vc >= VS_BEGIN) && (r_vc < VS_END));
  assign w_active     = (r_hc < HC_ACTIVE) && (r_vc < VC_ACTIVE);
  assign w_frameStart = (r_hc == '0) && (r_vc == '0);

  // Raster counters. A resync only ever reloads the line counter at a line
  // boundary, so every line keeps its full length and hsync never glitches.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hc      <= '0;
      r_vc      <= '0;
      r_pending <= 1'b0;
    end else if (w_hcWrap) begin
      r_hc      <= '0;
      r_pending <= 1'b0;
      if (r_pending || i_sync) begin
        r_vc <= VC_RESYNC;
      end else if (r_vc == VC_LAST) begin
        r_vc <= '0;
      end else begin
        r_vc <= r_vc + 1'b1;
      end
    end else begin
      r_hc      <= r_hc + 1'b1;
      r_pending <= r_pending | i_sync;
    end
  end

  // Read address generation. r_addr always holds the address for the current
  // raster position; at the last window pixel of a line it is preloaded with
  // the start of the next line (same row again, or the next source row).
  // After the last source row the row base folds back to 0 so the address
  // never points past the end of the buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr    <= '0;
      r_rowBase <= '0;
      r_xrep    <= '0;
      r_yrep    <= '0;
    end else if (w_resync || w_frameWrap) begin
      r_addr    <= '0;
      r_rowBase <= '0;
      r_xrep    <= '0;
      r_yrep    <= '0;
    end else if (w_lineEnd) begin
      r_xrep <= '0;
      if (r_yrep == REP_LAST) begin
        r_yrep <= '0;
        if (r_rowBase == LAST_ROW) begin
          r_rowBase <= '0;
          r_addr    <= '0;
        end else begin
          r_rowBase <= r_rowBase + ROW_STEP;
          r_addr    <= r_rowBase + ROW_STEP;
        end
      end else begin
        r_yrep <= r_yrep + 1'b1;
        r_addr <= r_rowBase;
      end
    end else if (w_inwin) begin
      if (r_xrep == REP_LAST) begin
        r_xrep <= '0;
        r_addr <= r_addr + 1'b1;
      end else begin
        r_xrep <= r_xrep + 1'b1;
      end
    end
  end

  // Two-stage output pipeline. Stage 1 catches the buffer data one cycle
  // after the address; the timing flags ride along so that every output
  // refers to the same raster position two cycles back.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data   <= '0;
      r_inwin1 <= 1'b0;
      r_inwin2 <= 1'b0;
      r_hs1    <= 1'b1;
      r_hs2    <= 1'b1;
      r_vs1    <= 1'b1;
      r_vs2    <= 1'b1;
      r_de1    <= 1'b0;
      r_de2    <= 1'b0;
      r_fs1    <= 1'b0;
      r_fs2    <= 1'b0;
    end else begin
      r_data   <= i_bram_dout;
      r_inwin1 <= w_inwin;
      r_inwin2 <= r_inwin1;
      r_hs1    <= w_hsyncN;
      r_hs2    <= r_hs1;
      r_vs1    <= w_vsyncN;
      r_vs2    <= r_vs1;
      r_de1    <= w_active;
      r_de2    <= r_de1;
      r_fs1    <= w_frameStart;
      r_fs2    <= r_fs1;
    end
  end

  assign o_bram_addr   = r_addr;
  assign o_bram_re     = w_inwin;
  assign o_hsync       = r_hs2;
  assign o_vsync       = r_vs2;
  assign o_de          = r_de2;
  assign o_frame_start = r_fs2;
  assign o_video_out   = r_inwin2 ? r_data : 8'd0;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
// Drives vga_scanout with a small raster (56 x 37 clocks per frame) so that
// many frames fit in a short run, models the frame buffer as a synchronous
// RAM, and compares every output against a position-based reference model.
module tb_vga_scanout;

  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int SW = 12, SH = 8, SC = 3, RL = 0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int X0 = (HA - SW * SC) / 2;
  localparam int Y0 = (VA - SH * SC) / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        syncPulse = 1'b0;
  logic [7:0]  bramDout = 8'd0;
  logic [13:0] bramAddr;
  logic        bramRe, hsync, vsync, de, frameStart;
  logic [7:0]  videoOut;

  logic [7:0]  mem [0:16383];
  bit          ffMode = 1'b0;
  bit          scanEn = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lastFall = -1;
  logic        prevHs = 1'b1;

  typedef struct {
    bit         valid;
    int         hc;
    int         vc;
    logic [7:0] pix;
  } posT;

  typedef struct {
    int         vc;
    int         hc;
    bit         ff;
    logic [7:0] video;
    bit         de;
    bit         hs;
    bit         vs;
    bit         fs;
  } vecT;

  posT h1, h2;
  int  mHc = 0, mVc = 0, sinceReset = 0;
  bit  mPend = 1'b0;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SRC_W(SW), .SRC_H(SH), .SCALE(SC), .RESYNC_LINE(RL)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_sync(syncPulse),
    .i_bram_dout(bramDout),
    .o_bram_addr(bramAddr),
    .o_bram_re(bramRe),
    .o_hsync(hsync),
    .o_vsync(vsync),
    .o_video_out(videoOut),
    .o_de(de),
    .o_frame_start(frameStart)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame buffer; ffMode forces every read to 0xFF.
  always @(posedge clk) begin
    if (bramRe) bramDout <= ffMode ? 8'hFF : mem[bramAddr];
  end

  function automatic bit inWin(int hc, int vc);
    return (hc >= X0) && (hc < X0 + SW * SC) && (vc >= Y0) && (vc < Y0 + SH * SC);
  endfunction

  function automatic int srcAddr(int hc, int vc);
    return ((vc - Y0) / SC) * SW + (hc - X0) / SC;
  endfunction

  // Expected {hsync, vsync, de, frameStart, video} for a raster position.
  function automatic logic [11:0] expOut(posT p);
    logic eh, ev, ed, ef;
    if (!p.valid) return {1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    eh = !((p.hc >= HA + HF) && (p.hc < HA + HF + HS));
    ev = !((p.vc >= VA + VF) && (p.vc < VA + VF + VS));
    ed = (p.hc < HA) && (p.vc < VA);
    ef = (p.hc == 0) && (p.vc == 0);
    return {eh, ev, ed, ef, p.pix};
  endfunction

  // Reference raster position: tracks where the counters are this cycle and
  // remembers the last two positions, along with the byte the buffer should
  // return for them, since outputs lag the counters by two clocks.
  always @(posedge clk) begin
    if (reset) begin
      mHc = 0;
      mVc = 0;
      mPend = 1'b0;
      h1.valid = 1'b0;
      h2.valid = 1'b0;
      sinceReset = 0;
    end else begin
      h2 = h1;
      h1.valid = 1'b1;
      h1.hc = mHc;
      h1.vc = mVc;
      h1.pix = !inWin(mHc, mVc) ? 8'h00 : (ffMode ? 8'hFF : mem[srcAddr(mHc, mVc)]);
      if (mHc == HT - 1) begin
        mHc = 0;
        mVc = (mPend || syncPulse) ? RL : (mVc + 1) % VT;
        mPend = 1'b0;
      end else begin
        mHc = mHc + 1;
        if (syncPulse) mPend = 1'b1;
      end
      sinceReset = sinceReset + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One clock: step to the falling edge, then compare all outputs with the
  // model and measure the hsync period.
  task automatic tick();
    logic        expRe;
    logic [13:0] expAddr, gotAddr;
    @(negedge clk);
    cyc++;
    if (scanEn) begin
      expRe   = inWin(mHc, mVc);
      expAddr = expRe ? 14'(srcAddr(mHc, mVc)) : 14'd0;
      gotAddr = expRe ? bramAddr : 14'd0;
      checkOutput($sformatf("scan v%0d h%0d", mVc, mHc),
                  32'({hsync, vsync, de, frameStart, videoOut, bramRe, gotAddr}),
                  32'({expOut(h2), expRe, expAddr}));
      if (prevHs && !hsync) begin
        if (lastFall >= 0) checkOutput("hsync period", cyc - lastFall, HT);
        lastFall = cyc;
      end
      prevHs = hsync;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lastFall = -1;
    prevHs = 1'b1;
  endtask

  task automatic waitCycle(input int k);
    int guard = 0;
    while (sinceReset < k && guard < 5000) begin
      tick();
      guard++;
    end
    if (sinceReset != k) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait: reached cycle %0d want %0d", sinceReset, k);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " hsync"}, 32'(hsync), 32'd1);
    checkOutput({tag, " vsync"}, 32'(vsync), 32'd1);
    checkOutput({tag, " de"}, 32'(de), 32'd0);
    checkOutput({tag, " frame_start"}, 32'(frameStart), 32'd0);
    checkOutput({tag, " video"}, 32'(videoOut), 32'd0);
    checkOutput({tag, " bram_re"}, 32'(bramRe), 32'd0);
    checkOutput({tag, " bram_addr"}, 32'(bramAddr), 32'd0);
  endtask

  // One probe: reach the cycle where raster position (vc,hc) appears on the
  // outputs, restarting from reset when the buffer mode changes or the
  // position has already passed.
  task automatic applyStimulus(input vecT v);
    int target;
    target = v.vc * HT + v.hc + 2;
    if (v.ff != ffMode || target <= sinceReset) begin
      ffMode = v.ff;
      doReset();
    end
    waitCycle(target);
    checkOutput($sformatf("probe v%0d h%0d ff%0d", v.vc, v.hc, v.ff),
                32'({videoOut, de, hsync, vsync, frameStart}),
                32'({v.video, v.de, v.hs, v.vs, v.fs}));
  endtask

  initial begin : watchdog
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecT vecs[$];
    int  deCnt, hsLow, vsLow, reCnt, fsCnt, lastRd;

    // Hand-derived probe table for the reduced raster: window x 2..37,
    // y 3..26, buffer holding addr[7:0].
    vecs.push_back('{0, 0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{3, 1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3, 5, 1'b0, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{4, 37, 1'b0, 8'd11, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{5, 45, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{6, 2, 1'b0, 8'd12, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{10, 20, 1'b0, 8'd30, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{12, 38, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{26, 37, 1'b0, 8'd95, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{27, 20, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{32, 10, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{36, 55, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{2, 20, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3, 1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3, 2, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{15, 30, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{20, 39, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{27, 20, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{33, 20, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0});

    for (int i = 0; i < 16384; i++) mem[i] = 8'(i);

    $display("[TB] reset and reset values");
    doReset();
    scanEn = 1'b1;
    checkResetValues("reset");

    $display("[TB] one free-running frame");
    waitCycle(2);
    deCnt = 0; hsLow = 0; vsLow = 0; reCnt = 0; fsCnt = 0; lastRd = -1;
    for (int i = 0; i < HT * VT; i++) begin
      deCnt += int'(de);
      hsLow += int'(!hsync);
      vsLow += int'(!vsync);
      fsCnt += int'(frameStart);
      if (bramRe) begin
        reCnt++;
        lastRd = int'(bramAddr);
      end
      tick();
    end
    checkOutput("frame de count", deCnt, HA * VA);
    checkOutput("frame hsync low", hsLow, HS * VT);
    checkOutput("frame vsync low", vsLow, VS * HT);
    checkOutput("frame start count", fsCnt, 1);
    checkOutput("frame read count", reCnt, SW * SC * SH * SC);
    checkOutput("frame last read", lastRd, SW * SH - 1);

    $display("[TB] probe table");
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] resync mid-frame");
    ffMode = 1'b0;
    doReset();
    waitCycle(10 * HT + 20);
    syncPulse = 1'b1;
    tick();
    syncPulse = 1'b0;
    waitCycle(11 * HT + 1);
    checkOutput("resync no early start", 32'(frameStart), 32'd0);
    waitCycle(11 * HT + 2);
    checkOutput("resync frame start", 32'(frameStart), 32'd1);
    waitCycle(14 * HT + 2);
    checkOutput("resync first read", 32'({bramRe, bramAddr}), 32'({1'b1, 14'd0}));
    waitCycle(14 * HT + 5);
    checkOutput("resync second addr", 32'({bramRe, bramAddr}), 32'({1'b1, 14'd1}));
    waitCycle(14 * HT + 7);
    checkOutput("resync video", 32'(videoOut), 32'd1);

    $display("[TB] resync on wrap and double pulse");
    doReset();
    waitCycle(5 * HT + 55);
    syncPulse = 1'b1;
    tick();
    syncPulse = 1'b0;
    waitCycle(6 * HT + 2);
    checkOutput("wrap resync start", 32'(frameStart), 32'd1);
    waitCycle(10 * HT + 10);
    syncPulse = 1'b1;
    tick();
    syncPulse = 1'b0;
    waitCycle(10 * HT + 20);
    syncPulse = 1'b1;
    tick();
    syncPulse = 1'b0;
    waitCycle(11 * HT + 2);
    checkOutput("double pulse start", 32'(frameStart), 32'd1);
    waitCycle(12 * HT + 2);
    checkOutput("double pulse single reload", 32'({frameStart, de}), 32'({1'b0, 1'b1}));

    $display("[TB] mid-frame reset");
    doReset();
    waitCycle(20 * HT + 13);
    doReset();
    checkResetValues("midframe");
    waitCycle(2);
    checkOutput("midframe restart", 32'(frameStart), 32'd1);
    waitCycle(VT * HT + 50);

    $display("[TB] random buffer contents and sync pulses");
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    doReset();
    for (int i = 0; i < 5 * HT * VT; i++) begin
      syncPulse = ($urandom_range(0, 599) == 0);
      tick();
    end
    syncPulse = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
